// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size encodings, FSM states and data-alignment helpers
package lsu_pkg;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_ILL = 2'b11;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_e;

  function automatic logic [63:0] store_wide(input logic [31:0] wdata, input logic [1:0] off);
    return {32'b0, wdata} << {off, 3'b000};
  endfunction

  // Right-justify the two-beat read buffer, then truncate and extend by access size.
  function automatic logic [31:0] load_extend(input logic [63:0] data, input logic [1:0] off,
                                              input logic [1:0] size, input logic uns);
    logic [31:0] raw;
    raw = 32'(data >> {off, 3'b000});
    case (size)
      SIZE_B:  return uns ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      SIZE_H:  return uns ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_mask.sv
// rtl/lsu_lane_mask.sv - byte-lane span decoder for possibly misaligned accesses
module lsu_lane_mask import lsu_pkg::*; (
  input  logic [1:0] addr_lo_i,
  input  logic [1:0] size_i,
  output logic [6:0] span_o,
  output logic       split_o
);

  logic [6:0] base;

  always_comb begin
    base = 7'b0;
    case (size_i)
      SIZE_B:  base = 7'b0000001;
      SIZE_H:  base = 7'b0000011;
      SIZE_W:  base = 7'b0001111;
      default: base = 7'b0;
    endcase
  end

  assign span_o  = base << addr_lo_i;
  assign split_o = |span_o[6:4];

endmodule

// File: rtl/lsu_access_ctrl.sv
// rtl/lsu_access_ctrl.sv - load/store access controller splitting misaligned requests into bus beats
module lsu_access_ctrl import lsu_pkg::*; (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  state_e      state_q;
  logic        req_ready_q, resp_valid_q, resp_err_q;
  logic [31:0] resp_rdata_q;
  logic        mem_req_q, mem_we_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic [3:0]  mem_be_q;
  logic [63:0] buf_q;
  logic [1:0]  off_q, size_q;
  logic        uns_q, we_q;
  logic [2:0]  span_hi_q;
  logic [31:0] wide_hi_q;

  logic [6:0]  span_d;
  logic        split_d;
  logic [63:0] wide_d;

  lsu_lane_mask u_lane_mask (
    .addr_lo_i (req_addr_i[1:0]),
    .size_i    (req_size_i),
    .span_o    (span_d),
    .split_o   (split_d)
  );

  assign wide_d = store_wide(req_wdata_i, req_addr_i[1:0]);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      buf_q        <= '0;
      off_q        <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      we_q         <= 1'b0;
      span_hi_q    <= '0;
      wide_hi_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i && req_ready_q) begin
            req_ready_q <= 1'b0;
            off_q       <= req_addr_i[1:0];
            size_q      <= req_size_i;
            uns_q       <= req_unsigned_i;
            we_q        <= req_we_i;
            span_hi_q   <= span_d[6:4];
            wide_hi_q   <= wide_d[63:32];
            if (req_size_i == SIZE_ILL) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              state_q     <= BEAT0;
              mem_req_q   <= 1'b1;
              mem_we_q    <= req_we_i;
              mem_addr_q  <= {req_addr_i[31:2], 2'b00};
              mem_be_q    <= span_d[3:0];
              mem_wdata_q <= wide_d[31:0];
            end
          end
        end
        BEAT0: begin
          if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            if (!we_q) buf_q[31:0] <= mem_rdata_i;
            if (|span_hi_q) begin
              // Beat1 is staged during the mandatory idle cycle; mem_req rises next cycle.
              state_q     <= BEAT1;
              mem_addr_q  <= mem_addr_q + 32'd4;
              mem_be_q    <= {1'b0, span_hi_q};
              mem_wdata_q <= wide_hi_q;
            end else begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= we_q ? '0 : load_extend({buf_q[63:32], mem_rdata_i}, off_q, size_q, uns_q);
            end
          end
        end
        BEAT1: begin
          if (!mem_req_q) begin
            mem_req_q <= 1'b1;
          end else if (mem_ack_i) begin
            mem_req_q    <= 1'b0;
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            if (!we_q) buf_q[63:32] <= mem_rdata_i;
            resp_rdata_q <= we_q ? '0 : load_extend({mem_rdata_i, buf_q[31:0]}, off_q, size_q, uns_q);
          end
        end
        default: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
        end
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_be_o     = mem_be_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_access_ctrl.sv
// tb/tb_lsu_access_ctrl.sv - directed self-checking bench for lsu_access_ctrl
module tb_lsu_access_ctrl;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [1:0]  req_size_i = '0;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_wdata_i = '0;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  lsu_access_ctrl dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
    .req_wdata_i(req_wdata_i),
    .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  // Presents a request for one cycle (cycle 0); returns positioned in cycle 1.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata);
    req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr; req_size_i = size;
    req_unsigned_i = uns; req_wdata_i = wdata;
    tick();
    req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0; req_size_i = '0;
    req_unsigned_i = 1'b0; req_wdata_i = '0;
  endtask

  task automatic test_reset;
    rstn_i = 1'b0;
    tick(); tick();
    rstn_i = 1'b1;
    n_cmp++; if (req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready_o); end
    n_cmp++; if ({resp_valid_o, resp_err_o} !== 2'b00) begin n_fail++; $display("FAIL reset_resp: got %b want 00", {resp_valid_o, resp_err_o}); end
    n_cmp++; if (resp_rdata_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", resp_rdata_o); end
    n_cmp++; if ({mem_req_o, mem_we_o, mem_be_o} !== 6'b0) begin n_fail++; $display("FAIL reset_mem_ctl: got %b want 000000", {mem_req_o, mem_we_o, mem_be_o}); end
    n_cmp++; if ({mem_addr_o, mem_wdata_o} !== 64'h0) begin n_fail++; $display("FAIL reset_mem_data: got %h want 0", {mem_addr_o, mem_wdata_o}); end
    tick();
  endtask

  task automatic test_word_load;
    issue(1'b0, 32'h100, 2'b10, 1'b0, 32'h0);
    n_cmp++; if ({mem_req_o, mem_we_o, mem_be_o} !== 6'b10_1111) begin n_fail++; $display("FAIL word_ctl: got %b want 101111", {mem_req_o, mem_we_o, mem_be_o}); end
    n_cmp++; if (mem_addr_o !== 32'h100) begin n_fail++; $display("FAIL word_addr: got %h want 00000100", mem_addr_o); end
    n_cmp++; if (req_ready_o !== 1'b0) begin n_fail++; $display("FAIL word_busy_ready: got %b want 0", req_ready_o); end
    mem_ack_i = 1'b1; mem_rdata_i = 32'h89ABCDEF;
    tick();
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    n_cmp++; if ({resp_valid_o, resp_err_o, mem_req_o} !== 3'b100) begin n_fail++; $display("FAIL word_resp_flags: got %b want 100", {resp_valid_o, resp_err_o, mem_req_o}); end
    n_cmp++; if (resp_rdata_o !== 32'h89ABCDEF) begin n_fail++; $display("FAIL word_rdata: got %h want 89abcdef", resp_rdata_o); end
    tick();
    n_cmp++; if ({req_ready_o, resp_valid_o} !== 2'b10) begin n_fail++; $display("FAIL word_idle: got %b want 10", {req_ready_o, resp_valid_o}); end
  endtask

  task automatic test_byte_load(input logic uns, input logic [31:0] exp);
    issue(1'b0, 32'h203, 2'b00, uns, 32'h0);
    n_cmp++; if ({mem_req_o, mem_be_o, mem_addr_o} !== {1'b1, 4'b1000, 32'h200}) begin n_fail++; $display("FAIL byte_beat: got %b %b %h want 1 1000 00000200", mem_req_o, mem_be_o, mem_addr_o); end
    mem_ack_i = 1'b1; mem_rdata_i = 32'h80FFFFFF;
    tick();
    mem_ack_i = 1'b0;
    n_cmp++; if ({resp_valid_o, resp_rdata_o} !== {1'b1, exp}) begin n_fail++; $display("FAIL byte_rdata uns=%b: got %b %h want 1 %h", uns, resp_valid_o, resp_rdata_o, exp); end
    tick();
  endtask

  task automatic test_split_store;
    issue(1'b1, 32'h3, 2'b01, 1'b0, 32'h0000BEEF);
    n_cmp++; if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o} !== {2'b11, 4'b1000, 32'h0}) begin n_fail++; $display("FAIL split_beat0: got %b %b %b %h want 1 1 1000 00000000", mem_req_o, mem_we_o, mem_be_o, mem_addr_o); end
    n_cmp++; if (mem_wdata_o[31:24] !== 8'hEF) begin n_fail++; $display("FAIL split_wdata0: got %h want ef", mem_wdata_o[31:24]); end
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    n_cmp++; if ({mem_req_o, resp_valid_o} !== 2'b00) begin n_fail++; $display("FAIL split_gap: got %b want 00", {mem_req_o, resp_valid_o}); end
    tick();
    n_cmp++; if ({mem_req_o, mem_be_o, mem_addr_o} !== {1'b1, 4'b0001, 32'h4}) begin n_fail++; $display("FAIL split_beat1: got %b %b %h want 1 0001 00000004", mem_req_o, mem_be_o, mem_addr_o); end
    n_cmp++; if (mem_wdata_o[7:0] !== 8'hBE) begin n_fail++; $display("FAIL split_wdata1: got %h want be", mem_wdata_o[7:0]); end
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    n_cmp++; if ({resp_valid_o, resp_err_o, resp_rdata_o} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL split_resp: got %b %b %h want 1 0 00000000", resp_valid_o, resp_err_o, resp_rdata_o); end
    tick();
  endtask

  task automatic test_wrap_load;
    issue(1'b0, 32'hFFFFFFFE, 2'b10, 1'b0, 32'h0);
    n_cmp++; if ({mem_be_o, mem_addr_o} !== {4'b1100, 32'hFFFFFFFC}) begin n_fail++; $display("FAIL wrap_beat0: got %b %h want 1100 fffffffc", mem_be_o, mem_addr_o); end
    mem_ack_i = 1'b1; mem_rdata_i = 32'h1122ABCD;
    tick();
    mem_ack_i = 1'b0; mem_rdata_i = 32'hDEADDEAD;
    tick();
    n_cmp++; if ({mem_req_o, mem_be_o, mem_addr_o} !== {1'b1, 4'b0011, 32'h0}) begin n_fail++; $display("FAIL wrap_beat1: got %b %b %h want 1 0011 00000000", mem_req_o, mem_be_o, mem_addr_o); end
    mem_ack_i = 1'b1; mem_rdata_i = 32'h55663344;
    tick();
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    n_cmp++; if ({resp_valid_o, resp_rdata_o} !== {1'b1, 32'h33441122}) begin n_fail++; $display("FAIL wrap_rdata: got %b %h want 1 33441122", resp_valid_o, resp_rdata_o); end
    tick();
  endtask

  task automatic test_illegal;
    issue(1'b0, 32'h40, 2'b11, 1'b0, 32'h0);
    n_cmp++; if ({resp_valid_o, resp_err_o, mem_req_o} !== 3'b110) begin n_fail++; $display("FAIL ill_flags: got %b want 110", {resp_valid_o, resp_err_o, mem_req_o}); end
    n_cmp++; if (resp_rdata_o !== 32'h0) begin n_fail++; $display("FAIL ill_rdata: got %h want 0", resp_rdata_o); end
    tick();
    n_cmp++; if ({req_ready_o, resp_valid_o, resp_err_o, mem_req_o} !== 4'b1000) begin n_fail++; $display("FAIL ill_after: got %b want 1000", {req_ready_o, resp_valid_o, resp_err_o, mem_req_o}); end
    tick();
  endtask

  task automatic test_wait_states;
    issue(1'b0, 32'h11, 2'b01, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({mem_req_o, mem_be_o, mem_addr_o, resp_valid_o} !== {1'b1, 4'b0110, 32'h10, 1'b0}) begin n_fail++; $display("FAIL wait_hold%0d: got %b %b %h %b want 1 0110 00000010 0", i, mem_req_o, mem_be_o, mem_addr_o, resp_valid_o); end
      tick();
    end
    mem_ack_i = 1'b1; mem_rdata_i = 32'h00CAFE00;
    tick();
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    n_cmp++; if ({resp_valid_o, resp_rdata_o} !== {1'b1, 32'hFFFFCAFE}) begin n_fail++; $display("FAIL wait_rdata: got %b %h want 1 ffffcafe", resp_valid_o, resp_rdata_o); end
    tick();
  endtask

  task automatic test_reset_mid;
    issue(1'b1, 32'h80, 2'b10, 1'b0, 32'h12345678);
    n_cmp++; if (mem_req_o !== 1'b1) begin n_fail++; $display("FAIL rmid_req: got %b want 1", mem_req_o); end
    rstn_i = 1'b0;
    tick();
    rstn_i = 1'b1; mem_ack_i = 1'b1;
    n_cmp++; if ({mem_req_o, resp_valid_o} !== 2'b00) begin n_fail++; $display("FAIL rmid_drop: got %b want 00", {mem_req_o, resp_valid_o}); end
    tick();
    mem_ack_i = 1'b0;
    n_cmp++; if ({req_ready_o, resp_valid_o, mem_req_o} !== 3'b100) begin n_fail++; $display("FAIL rmid_ack_ignored: got %b want 100", {req_ready_o, resp_valid_o, mem_req_o}); end
    issue(1'b0, 32'h1, 2'b00, 1'b1, 32'h0);
    n_cmp++; if ({mem_req_o, mem_be_o} !== 5'b1_0010) begin n_fail++; $display("FAIL rmid_new_beat: got %b want 10010", {mem_req_o, mem_be_o}); end
    mem_ack_i = 1'b1; mem_rdata_i = 32'h0000AB00;
    tick();
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    n_cmp++; if ({resp_valid_o, resp_rdata_o} !== {1'b1, 32'h000000AB}) begin n_fail++; $display("FAIL rmid_new_rdata: got %b %h want 1 000000ab", resp_valid_o, resp_rdata_o); end
    tick();
  endtask

  task automatic test_back_to_back;
    issue(1'b1, 32'h104, 2'b10, 1'b0, 32'hA5A5A5A5);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h208; req_size_i = 2'b10; req_wdata_i = 32'h5A5A5A5A;
    n_cmp++; if ({resp_valid_o, req_ready_o} !== 2'b10) begin n_fail++; $display("FAIL b2b_resp_cycle: got %b want 10", {resp_valid_o, req_ready_o}); end
    tick();
    n_cmp++; if ({req_ready_o, mem_req_o} !== 2'b10) begin n_fail++; $display("FAIL b2b_accept_cycle: got %b want 10", {req_ready_o, mem_req_o}); end
    tick();
    req_valid_i = 1'b0;
    n_cmp++; if ({mem_req_o, mem_addr_o, mem_wdata_o} !== {1'b1, 32'h208, 32'h5A5A5A5A}) begin n_fail++; $display("FAIL b2b_second: got %b %h %h want 1 00000208 5a5a5a5a", mem_req_o, mem_addr_o, mem_wdata_o); end
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_load(1'b0, 32'hFFFFFF80);
    test_byte_load(1'b1, 32'h00000080);
    test_split_store();
    test_wrap_load();
    test_illegal();
    test_wait_states();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_access_ctrl.md
# lsu_access_ctrl

Load/store access controller between the CPU core's memory stage and the 32-bit data-memory bus. It takes one byte, halfword or word request, derives the byte-lane enables from address offset and size, and runs the bus transaction. A request that crosses a word boundary is split into two aligned beats. The controller merges read lanes, sign- or zero-extends them, and returns one response per request.

## Interface
- No parameters. Bus width is fixed at 32 bits, address width at 32 bits.
- `clk` in 1: single clock, rising edge.
- `rstn` in 1: synchronous, active-low reset.
- `req_valid` in 1: core request strobe.
- `req_ready` out 1: controller can accept; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_size` in 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `req_unsigned` in 1: zero-extend loads when 1, sign-extend when 0.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle response pulse. There is no backpressure on the response.
- `resp_rdata` out 32: extended load data. It is 0 for stores and errors.
- `resp_err` out 1: illegal size. Valid with `resp_valid`.
- `mem_req` out 1: bus request. Held until `mem_ack`.
- `mem_addr` out 32: word-aligned address, `[1:0]` = 00.
- `mem_we` out 1: bus write.
- `mem_be` out 4: byte-lane enables. Bit n selects byte lane n.
- `mem_wdata` out 32: lane-positioned write data.
- `mem_ack` in 1: bus completes the current beat.
- `mem_rdata` in 32: read data. Valid only with `mem_ack` on a read.

## Operation
- States:
  - IDLE: `req_ready`=1.
  - BEAT0, BEAT1: `mem_req`=1.
  - RESP: `resp_valid`=1.
- Handshake: a request is accepted on `req_valid && req_ready`. All request fields are registered at acceptance; the core may change its inputs afterwards.
- Span mask: 7-bit `span = ((1 << (1 << size)) - 1) << addr[1:0]`.
  - Beat0: `mem_be = span[3:0]`, `mem_addr = {addr[31:2], 2'b00}`.
  - Beat1 exists iff `span[6:4] != 0`. It uses `mem_be = {1'b0, span[6:4]}` and `mem_addr` = beat0 address + 4, with 32-bit wrap: 0xFFFFFFFC + 4 = 0x00000000.
- Store data: 64-bit `wide = {32'b0, wdata} << (8*addr[1:0])`. Beat0 drives `wide[31:0]`, beat1 drives `wide[63:32]`. Lanes with `mem_be` = 0 are don't-care but driven from `wide`.
- Load data: the beat0 ack captures `mem_rdata` into `buf[31:0]`; the beat1 ack captures it into `buf[63:32]`. Then `raw = buf >> (8*addr[1:0])`, truncated to 8/16/32 bits by size and extended per `req_unsigned`.
- Transitions:
  - IDLE to BEAT0 on accept with legal size.
  - IDLE to RESP on accept with size 11. No bus access occurs; `resp_err`=1 and `resp_rdata`=0.
  - BEAT0 on `mem_ack`: to BEAT1 if split, else RESP.
  - BEAT1 on `mem_ack`: to RESP.
  - RESP to IDLE unconditionally.
- `mem_req` drops in the cycle after the ack. Between beats, `mem_req` is low for exactly one cycle.

## Timing
- Reset: state IDLE. Outputs after reset:
  - `req_ready`=1.
  - `resp_valid`=0, `resp_err`=0, `resp_rdata`=0.
  - `mem_req`=0, `mem_we`=0, `mem_be`=0, `mem_addr`=0, `mem_wdata`=0.
  - `buf`=0.
- Reset mid-operation: on the next edge the state returns to IDLE and `mem_req` drops. The beat is abandoned and no response is issued. A later `mem_ack` is ignored in IDLE.
- Latency, with accept in cycle 0 and zero-wait bus (ack in the first `mem_req` cycle):
  - Single beat: `mem_req` in cycle 1, `resp_valid` in cycle 2.
  - Split access: beat1 `mem_req` in cycle 3, `resp_valid` in cycle 4.
  - Error: `resp_valid` in cycle 1.
- Each bus wait cycle adds one cycle.
- Throughput: the next accept is possible in the cycle after RESP.
- All outputs are registered. There are no combinational paths from `mem_ack` or `req_*` to outputs.

## Structure
- Shared package `lsu_pkg`:
  - size encodings `SIZE_B`/`SIZE_H`/`SIZE_W`/`SIZE_ILL`.
  - state enum `{IDLE, BEAT0, BEAT1, RESP}`.
- Sub-module `lsu_lane_mask`: combinational. Takes `addr[1:0]` and `size`, produces the 7-bit `span` and a `split` flag. It is the generalised form of the existing byte-lane decoder, extended to misaligned spans.

## Test plan
- Aligned word load: addr 0x100, size 10, mem_rdata 0x89ABCDEF, zero-wait bus → `mem_be`=1111, `mem_addr`=0x100, `resp_rdata`=0x89ABCDEF in cycle 2.
- Byte load signed: addr 0x203, size 00, mem_rdata 0x80FFFFFF → `mem_be`=1000, `resp_rdata`=0xFFFFFF80. The same access with `req_unsigned`=1 → 0x00000080.
- Split halfword store: addr 0x3, wdata 0x0000BEEF → beat0 `mem_addr`=0x0, `mem_be`=1000, `mem_wdata[31:24]`=0xEF; beat1 `mem_addr`=0x4, `mem_be`=0001, `mem_wdata[7:0]`=0xBE; `resp_valid` in cycle 4.
- Split word load at wrap: addr 0xFFFFFFFE, beat0 rdata 0x1122xxxx, beat1 rdata 0xxxxx3344 → `mem_addr` 0xFFFFFFFC then 0x00000000, `resp_rdata`=0x33441122.
- Illegal size 11 → no `mem_req` ever. `resp_valid`=1 with `resp_err`=1 and `resp_rdata`=0 in cycle 1.
- Wait states and reset:
  - Wait states: ack delayed 3 cycles → `mem_req`, `mem_addr`, `mem_be` stay stable until the ack.
  - Reset: `rstn`=0 during BEAT0 → `mem_req`=0 next cycle, no `resp_valid`, and a new request is accepted right after reset.
